// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// fetch_ctrl : fetch-stage PC sequencer with a 2-entry fetch queue.
//              Optional macro FETCH_STATIC_BTAKEN_EN enables static taken
//              prediction for backward branches.
// Revision   : 1.0
// ============================================================================
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ifetch_req,
    output logic [31:0] ifetch_addr,
    input  logic        ifetch_gnt,
    input  logic        ifetch_rvalid,
    input  logic [31:0] ifetch_rdata,
    output logic        fet_valid,
    output logic [31:0] fet_instr,
    output logic [31:0] fet_pc,
    input  logic        dec_ready,
    input  logic        isjal,
    input  logic        isjalr,
    input  logic        isbxx,
    input  logic        predict_bxxtaken,
    input  logic        ismret,
    input  logic        isecallbk,
    input  logic [31:0] jaloffset,
    input  logic [31:0] bxxoffset,
    input  logic [31:0] jalroffset,
    input  logic [31:0] jalr_xn,
    input  logic        jalr_dep,
    input  logic        exe_redirect,
    input  logic [31:0] exe_redirect_pc,
    input  logic        trap_req,
    input  logic [31:0] trap_pc,
    output logic        fet_redirect
);

    typedef enum logic [1:0] {
        ST_BOOT      = 2'd0,
        ST_RUN       = 2'd1,
        ST_JALR_WAIT = 2'd2,
        ST_SYS_WAIT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hd_instr_q, hd_instr_d;
    logic [31:0] hd_pc_q, hd_pc_d;
    logic [31:0] tl_instr_q, tl_instr_d;
    logic [31:0] tl_pc_q, tl_pc_d;
    logic [1:0]  count_q, count_d;
    logic        inflight_q, inflight_d;
    logic        infl_epoch_q, infl_epoch_d;
    logic [31:0] infl_addr_q, infl_addr_d;
    logic        epoch_q, epoch_d;

    logic        w_global;
    logic [31:0] w_global_pc;
    logic        w_accept;
    logic        w_jalr_stall;
    logic        w_bxx_taken;
    logic [31:0] w_bxx_tgt;
    logic [31:0] w_jal_tgt;
    logic [31:0] w_jalr_tgt;
    logic        w_local_redirect;
    logic        w_sys;
    logic [31:0] w_local_tgt;
    logic [2:0]  w_occupancy;
    logic [2:0]  w_limit;
    logic        w_issue;
    logic        w_resp_ok;
    logic        w_flush;
    logic [1:0]  w_cnt_pop;

    // Commit-side redirects override everything except the boot cycle.
    assign w_global    = (state_q != ST_BOOT) & (exe_redirect | trap_req);
    assign w_global_pc = exe_redirect ? exe_redirect_pc : trap_pc;

    assign fet_valid    = (count_q != 2'd0) & ~w_global;
    assign fet_instr    = hd_instr_q;
    assign fet_pc       = hd_pc_q;
    assign w_jalr_stall = isjalr & jalr_dep;
    assign w_accept     = fet_valid & dec_ready & ~w_jalr_stall;

    assign w_jal_tgt  = fet_pc + jaloffset;
    assign w_jalr_tgt = (jalr_xn + jalroffset) & ~32'h1;

`ifdef FETCH_STATIC_BTAKEN_EN
    assign w_bxx_taken = isbxx & predict_bxxtaken;
    assign w_bxx_tgt   = fet_pc + bxxoffset;
`else
    logic w_unused_bxx;
    assign w_bxx_taken  = 1'b0;
    assign w_bxx_tgt    = 32'h0;
    assign w_unused_bxx = ^{isbxx, predict_bxxtaken, bxxoffset};
`endif

    // Credit: slots already owned plus the one in flight, less the slot freed now.
    assign w_occupancy = {1'b0, count_q} + {2'b00, inflight_q};
    assign w_limit     = 3'd2 + {2'b00, w_accept};
    assign ifetch_req  = (state_q == ST_RUN) & ~w_global & (w_occupancy < w_limit);
    assign ifetch_addr = pc_q;
    assign w_issue     = ifetch_req & ifetch_gnt;

    assign w_resp_ok = ifetch_rvalid & inflight_q & (infl_epoch_q == epoch_q);

    always_comb begin
        w_local_redirect = 1'b0;
        w_sys            = 1'b0;
        w_local_tgt      = 32'h0;
        if (w_accept) begin
            if (isjal) begin
                w_local_redirect = 1'b1;
                w_local_tgt      = w_jal_tgt;
            end else if (w_bxx_taken) begin
                w_local_redirect = 1'b1;
                w_local_tgt      = w_bxx_tgt;
            end else if (isjalr) begin
                w_local_redirect = 1'b1;
                w_local_tgt      = w_jalr_tgt;
            end else if (ismret | isecallbk) begin
                w_sys = 1'b1;
            end
        end
    end

    assign fet_redirect = w_local_redirect;
    assign w_flush      = w_global | w_local_redirect | w_sys;

    always_comb begin
        hd_instr_d = hd_instr_q;
        hd_pc_d    = hd_pc_q;
        tl_instr_d = tl_instr_q;
        tl_pc_d    = tl_pc_q;
        w_cnt_pop  = count_q - {1'b0, w_accept};
        if (w_accept) begin
            hd_instr_d = tl_instr_q;
            hd_pc_d    = tl_pc_q;
        end
        if (w_resp_ok) begin
            if (w_cnt_pop == 2'd0) begin
                hd_instr_d = ifetch_rdata;
                hd_pc_d    = infl_addr_q;
            end else begin
                tl_instr_d = ifetch_rdata;
                tl_pc_d    = infl_addr_q;
            end
        end
        count_d = w_cnt_pop + {1'b0, w_resp_ok};
        // A flush also swallows any response landing in the same cycle.
        if (w_flush) begin
            count_d = 2'd0;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        epoch_d      = epoch_q;
        inflight_d   = inflight_q;
        infl_epoch_d = infl_epoch_q;
        infl_addr_d  = infl_addr_q;

        if (ifetch_rvalid) begin
            inflight_d = 1'b0;
        end
        if (w_issue) begin
            inflight_d   = 1'b1;
            infl_epoch_d = epoch_q;
            infl_addr_d  = pc_q;
            pc_d         = pc_q + 32'd4;
        end

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (fet_valid & w_jalr_stall) begin
                    state_d = ST_JALR_WAIT;
                end else if (w_sys) begin
                    state_d = ST_SYS_WAIT;
                end
            end
            ST_JALR_WAIT: begin
                if (w_local_redirect) begin
                    state_d = ST_RUN;
                end
            end
            ST_SYS_WAIT: begin
                state_d = ST_SYS_WAIT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        if (w_local_redirect | w_sys) begin
            epoch_d = ~epoch_q;
        end
        if (w_local_redirect) begin
            pc_d = w_local_tgt;
        end

        if (w_global) begin
            pc_d    = w_global_pc;
            epoch_d = ~epoch_q;
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            hd_instr_q   <= 32'h0;
            hd_pc_q      <= 32'h0;
            tl_instr_q   <= 32'h0;
            tl_pc_q      <= 32'h0;
            count_q      <= 2'd0;
            inflight_q   <= 1'b0;
            infl_epoch_q <= 1'b0;
            infl_addr_q  <= 32'h0;
            epoch_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hd_instr_q   <= hd_instr_d;
            hd_pc_q      <= hd_pc_d;
            tl_instr_q   <= tl_instr_d;
            tl_pc_q      <= tl_pc_d;
            count_q      <= count_d;
            inflight_q   <= inflight_d;
            infl_epoch_q <= infl_epoch_d;
            infl_addr_q  <= infl_addr_d;
            epoch_q      <= epoch_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch-stage sequencer that owns the program counter and the instruction-memory request port.
- Holds returned instructions in a 2-entry fetch queue; the queue head drives the mini-decoder and the decode stage.
- Acts on the mini-decoder's results at the head: JAL, predicted-taken branch, JALR (waits out register dependence), MRET/ECALL/EBREAK (stops fetch until commit).
- Accepts execute-stage mispredict redirects and trap/return redirects.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
ifetch_req  out  1  fetch request valid
ifetch_addr  out  32  fetch address (always pc_q)
ifetch_gnt  in  1  request accepted this cycle
ifetch_rvalid  in  1  response valid; arrives exactly 1 cycle after a granted request
ifetch_rdata  in  32  returned instruction
fet_valid  out  1  queue head valid
fet_instr  out  32  head instruction (feeds mini-decoder and decode)
fet_pc  out  32  head PC
dec_ready  in  1  decode accepts head this cycle
isjal, isjalr, isbxx, predict_bxxtaken, ismret, isecallbk  in  1 each  mini-decode of fet_instr
jaloffset, bxxoffset, jalroffset, jalr_xn  in  32 each  offsets and JALR base operand
jalr_dep  in  1  JALR base not yet written
exe_redirect  in  1  mispredict flush
exe_redirect_pc  in  32  corrected PC
trap_req  in  1  trap or MRET commit redirect
trap_pc  in  32  mtvec or mepc target
fet_redirect  out  1  pulse on locally predicted redirect

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=BOOT, pc_q=RESET_PC, queue empty, inflight=0, epoch=0.
  - Outputs: ifetch_req=0, fet_valid=0, fet_redirect=0, fet_instr=0, fet_pc=0.
  - Reset mid-operation discards queue and inflight with no response accepted.
- States: BOOT, RUN, JALR_WAIT, SYS_WAIT.
  - BOOT -> RUN after one cycle.
- accept = fet_valid & dec_ready & ~(isjalr & jalr_dep); the head pops on accept.
- Issue:
  - ifetch_req = (state==RUN) & (count + inflight - accept < 2), where count is queue occupancy 0..2.
  - On ifetch_gnt: inflight<=1, infl_epoch<=epoch, pc_q<=pc_q+4 (32-bit wrap).
- Response:
  - On ifetch_rvalid with infl_epoch==epoch: push {rdata, addr}. Otherwise drop.
  - inflight clears unless re-granted in the same cycle.
  - Push and pop in the same cycle are allowed; the credit rule guarantees no overflow.
- RUN, head decisions on accept:
  - isjal: target=fet_pc+jaloffset.
  - isbxx & taken-prediction: target=fet_pc+bxxoffset.
  - isjalr & ~jalr_dep: target=(jalr_xn+jalroffset) & ~1.
  - isjalr & jalr_dep: no accept; next state JALR_WAIT.
  - ismret|isecallbk: accept, flush the younger queue entry, epoch toggles; next state SYS_WAIT.
  - Otherwise: plain pop.
- Redirect action: pc_q<=target, flush the younger entry, epoch toggles, fet_redirect=1 for that cycle.
- JALR_WAIT:
  - No issue; head held stable.
  - When ~jalr_dep & dec_ready: accept, redirect to the JALR target, return to RUN.
- SYS_WAIT: no issue; wait for trap_req or exe_redirect.
- Global priority exe_redirect > trap_req > local decisions, from any state except BOOT:
  - pc_q<=redirect PC, queue cleared, epoch toggles, state RUN.
  - fet_valid forced 0 that cycle, so no accept.
  - A new fetch issues the next cycle.
- Same cycle as a local redirect: the global redirect wins and the local target is discarded.
- All adds are 32-bit modulo.

Optional Feature:
FETCH_STATIC_BTAKEN_EN
- Defined: branches predicted taken when predict_bxxtaken=1 (backward offset).
- Undefined: all branches predicted not-taken; isbxx is a plain pop and no branch ever asserts fet_redirect.

Test Plan:
- Reset, then dec_ready=1 and an always-granting memory returning NOPs -> first ifetch_addr=RESET_PC; fet_pc sequence 0,4,8,...; one accept per cycle after 3-cycle startup.
- JAL at PC 0x10, offset +0x100 -> fet_redirect pulse; next accepted fet_pc=0x110; the in-flight 0x18 response is dropped.
- JALR with jalr_dep=1 for 3 cycles, jalr_xn=0x2001, jalroffset=2 -> head held 3 cycles, no requests; then target 0x2002.
- BEQ at 0x40, offset -8 -> with macro next fet_pc=0x38; without macro next fet_pc=0x44.
- ECALL at 0x80 -> SYS_WAIT, ifetch_req=0; trap_req with trap_pc=0x100 -> next fetch at 0x100.
- exe_redirect=1 to 0x300 in the same cycle as a JAL at the head and dec_ready=0 with a full queue -> queue cleared; next ifetch_addr=0x300; no pop or overflow.
